// File: rtl/fila_registradores_n.sv
// First-word-fall-through event FIFO: DEPTH entries of N bits, with occupancy count,
// full/empty decodes of registered state and sticky overflow/underflow flags.
module fila_registradores_n #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          flush,
  input  logic          push,
  input  logic [N-1:0]  D,
  input  logic          pop,
  output logic [N-1:0]  Q,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  logic [N-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rp;
  logic [AW-1:0] r_wp;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_underflow;
  state_t        r_state;

  logic          w_pop_acc;
  logic          w_push_acc;
  logic          w_push_rej;
  logic          w_pop_rej;
  logic [CW-1:0] w_count_nxt;
  state_t        w_state_nxt;

  // Acceptance: a pop frees a slot in the same edge, so push-with-pop is legal when full.
  always_comb begin
    w_pop_acc   = pop & (r_state != S_EMPTY);
    w_push_acc  = push & ((r_state != S_FULL) | w_pop_acc);
    w_push_rej  = push & ~w_push_acc & ~flush;
    w_pop_rej   = pop & ~w_pop_acc & ~flush;
    w_count_nxt = r_count;
    if (w_push_acc && !w_pop_acc) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop_acc && !w_push_acc) begin
      w_count_nxt = r_count - CW'(1);
    end
    if (flush) begin
      w_count_nxt = '0;
    end
    w_state_nxt = S_PARTIAL;
    if (w_count_nxt == '0) begin
      w_state_nxt = S_EMPTY;
    end else if (w_count_nxt == CW'(DEPTH)) begin
      w_state_nxt = S_FULL;
    end
  end

  // Storage needs no reset: Q is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (!flush && w_push_acc) begin
      r_mem[r_wp] <= D;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_rp        <= '0;
      r_wp        <= '0;
      r_count     <= '0;
      r_state     <= S_EMPTY;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_rp        <= '0;
      r_wp        <= '0;
      r_count     <= '0;
      r_state     <= S_EMPTY;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_pop_acc) begin
        r_rp <= r_rp + AW'(1);
      end
      if (w_push_acc) begin
        r_wp <= r_wp + AW'(1);
      end
      r_count <= w_count_nxt;
      r_state <= w_state_nxt;
      if (w_push_rej) begin
        r_overflow <= 1'b1;
      end
      if (w_pop_rej) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign Q         = (r_state == S_EMPTY) ? '0 : r_mem[r_rp];
  assign empty     = (r_state == S_EMPTY);
  assign full      = (r_state == S_FULL);
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_fila_registradores_n.sv
// Randomised scoreboard bench for fila_registradores_n (N=32, DEPTH=4) against a queue model.
module tb_fila_registradores_n;

  localparam int unsigned N     = 32;
  localparam int unsigned DEPTH = 4;

  logic          clock;
  logic          clear;
  logic          flush;
  logic          push;
  logic [N-1:0]  D;
  logic          pop;
  logic [N-1:0]  Q;
  logic          empty;
  logic          full;
  logic [2:0]    count;
  logic          overflow;
  logic          underflow;

  fila_registradores_n #(.N(N), .DEPTH(DEPTH)) dut (
    .clock(clock), .clear(clear), .flush(flush), .push(push), .D(D), .pop(pop),
    .Q(Q), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int unsigned cyc;
    logic [31:0] q;
    logic [2:0]  cnt;
    logic        e;
    logic        f;
    logic        o;
    logic        u;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  // Behavioural reference: a plain queue plus two sticky bits.
  logic [31:0] mq[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic fl, input logic pu, input logic po, input logic [31:0] d);
    bit pop_ok, push_ok;
    if (fl) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      pop_ok  = po && (mq.size() > 0);
      push_ok = pu && ((mq.size() < DEPTH) || pop_ok);
      if (po && !pop_ok)  m_unf = 1'b1;
      if (pu && !push_ok) m_ovf = 1'b1;
      if (pop_ok)  void'(mq.pop_front());
      if (push_ok) mq.push_back(d);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.cyc = cyc;
    e.q   = (mq.size() > 0) ? mq[0] : 32'd0;
    e.cnt = 3'(mq.size());
    e.e   = (mq.size() == 0);
    e.f   = (mq.size() == DEPTH);
    e.o   = m_ovf;
    e.u   = m_unf;
    sb.push_back(e);
  endtask

  // Monitor: outputs depend only on registered state, so the negedge sees stable values.
  always @(negedge clock) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("Q",         Q,                 e.q);
      chk("count",     32'(count),        32'(e.cnt));
      chk("empty",     32'(empty),        32'(e.e));
      chk("full",      32'(full),         32'(e.f));
      chk("overflow",  32'(overflow),     32'(e.o));
      chk("underflow", 32'(underflow),    32'(e.u));
    end
  end

  task automatic cycle(input logic fl, input logic pu, input logic po, input logic [31:0] d);
    @(negedge clock);
    clear = 1'b0;
    flush = fl;
    push  = pu;
    pop   = po;
    D     = d;
    model_step(fl, pu, po, d);
    push_exp();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, $urandom);
  endtask

  task automatic check_reset_now(input string tag);
    chk({tag, ".count"},     32'(count),     32'd0);
    chk({tag, ".empty"},     32'(empty),     32'd1);
    chk({tag, ".full"},      32'(full),      32'd0);
    chk({tag, ".Q"},         Q,              32'd0);
    chk({tag, ".overflow"},  32'(overflow),  32'd0);
    chk({tag, ".underflow"}, 32'(underflow), 32'd0);
  endtask

  // Async clear raised mid low-phase; outputs must drop without any clock edge.
  task automatic do_clear();
    @(negedge clock);
    #2;
    clear = 1'b1;
    flush = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    #1;
    check_reset_now("clear");
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    push_exp();
  endtask

  task automatic fill_ref();
    cycle(1'b0, 1'b1, 1'b0, 32'd5);
    cycle(1'b0, 1'b1, 1'b0, 32'd11);
    cycle(1'b0, 1'b1, 1'b0, 32'd111);
    cycle(1'b0, 1'b1, 1'b0, 32'd53);
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, 1'b1, $urandom);
  endtask

  initial begin
    int bias;
    int r;
    clear = 1'b1;
    flush = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    D     = '0;
    #2;
    check_reset_now("init");

    // Fill to full, then drain in order.
    fill_ref();
    idle();
    drain(4);
    idle();

    // Rejected push on full raises overflow and loses the word.
    fill_ref();
    cycle(1'b0, 1'b1, 1'b0, 32'd7);
    drain(4);
    idle();

    // Simultaneous push/pop while full, with pointer wrap.
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    fill_ref();
    cycle(1'b0, 1'b1, 1'b1, 32'd9);
    drain(4);
    idle();

    // Push/pop on empty: pop rejected, push stored.
    cycle(1'b0, 1'b1, 1'b1, 32'd42);
    idle();

    // Flush with push at count=3 and overflow set.
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 1'b0, 32'(i));
    cycle(1'b0, 1'b1, 1'b0, 32'd99);
    cycle(1'b0, 1'b0, 1'b1, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd77);
    idle();

    // Async clear while partially filled with flags set.
    cycle(1'b0, 1'b0, 1'b1, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 32'd2);
    do_clear();
    idle();

    // Random traffic, with push/pop bias drifting to visit full and empty often.
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) bias = $urandom_range(15, 85);
      r = $urandom_range(0, 199);
      if (r == 0) begin
        do_clear();
      end else if (r < 5) begin
        cycle(1'b1, 1'($urandom), 1'($urandom), $urandom);
      end else begin
        cycle(1'b0, 1'($urandom_range(0, 99) < bias),
              1'($urandom_range(0, 99) >= bias), $urandom);
      end
    end
    idle();
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
